apb_slave_mux_32bit: RTL and testbench

Downstream APB fabric stage for the UART/MDIO-to-APB control path. Takes the single 32-bit APB master port produced by the UART control bridge, decodes the upper address bits and forwards each transfer to one of NUM_SLV downstream register slaves. Returns the selected slave's ready/read data to the bridge, and returns an error word for unmapped or stalled accesses, so that a bad address never hangs the UART command loop.

---
 rtl/apb_fabric_pkg.sv | 22 ++
 rtl/apb_timeout_cnt.sv | 28 ++
 rtl/apb_slave_mux_32bit.sv | 191 +++++++++++++++++++
 tb/tb_apb_slave_mux_32bit.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_fabric_pkg.sv
// Shared definitions for the APB fabric: FSM states, default error/timeout constants, index width helper.
package apb_fabric_pkg;

    localparam int unsigned TO_CNT_W = 16;
    localparam int unsigned ERR_CNT_W = 8;

    localparam logic [31:0]         ERR_DATA_DEF    = 32'hDEAD_BEEF;
    localparam logic [TO_CNT_W-1:0] TIMEOUT_CYC_DEF = 16'd1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    // Width of the slave index register; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase watchdog: cleared before ACCESS, counts ACCESS cycles, flags when the limit is reached.
module apb_timeout_cnt
    import apb_fabric_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                en,
    input  logic [TO_CNT_W-1:0] limit,
    output logic                expire_c
);

    logic [TO_CNT_W-1:0] cnt;

    // Cycle counter; holds at its value outside ACCESS until the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TO_CNT_W'(1);
        end
    end

    assign expire_c = en && (cnt == limit);

endmodule

// File: rtl/apb_slave_mux_32bit.sv
// APB 1-to-NUM_SLV address-decoding mux with error response for unmapped accesses.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module apb_slave_mux_32bit
    import apb_fabric_pkg::*;
#(
    parameter int unsigned          NUM_SLV     = 4,
    parameter int unsigned          AW          = 24,
    parameter int unsigned          DW          = 32,
    parameter int unsigned          SEL_LSB     = 20,
    parameter logic [TO_CNT_W-1:0]  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [DW-1:0]        ERR_DATA    = DW'(ERR_DATA_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_ce,
    input  logic [AW-1:0]            s_addr,
    input  logic [DW-1:0]            s_wdata,
    input  logic                     s_enable,
    input  logic                     s_we,
    output logic                     s_rdy,
    output logic [DW-1:0]            s_rdata,
    output logic [NUM_SLV-1:0]       m_ce,
    output logic [AW-1:0]            m_addr,
    output logic [DW-1:0]            m_wdata,
    output logic                     m_enable,
    output logic                     m_we,
    input  logic [NUM_SLV-1:0]       m_rdy,
    input  logic [NUM_SLV*DW-1:0]    m_rdata,
    output logic                     err_pulse,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int unsigned IW = idx_width(NUM_SLV);

    apb_state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;

    logic [IW-1:0]      req_idx_c;
    logic               req_mapped_c;
    logic [NUM_SLV-1:0] req_oh_c;
    logic [NUM_SLV-1:0] sel_oh_c;
    logic               sel_rdy_c;
    logic [DW-1:0]      sel_rdata_c;
    logic               timeout_c;

    logic [NUM_SLV-1:0] m_ce_d;
    logic [AW-1:0]      m_addr_d;
    logic [DW-1:0]      m_wdata_d;
    logic               m_enable_d;
    logic               m_we_d;
    logic               s_rdy_d;
    logic [DW-1:0]      s_rdata_d;
    logic               err_pulse_d;

    // Address decode and selected-slave return mux. The whole field above SEL_LSB
    // is compared so that addresses beyond the last slave are rejected, not aliased.
    always_comb begin
        req_idx_c    = IW'(s_addr >> SEL_LSB);
        req_mapped_c = (s_addr >> SEL_LSB) < AW'(NUM_SLV);
        req_oh_c     = '0;
        sel_oh_c     = '0;
        sel_rdy_c    = 1'b0;
        sel_rdata_c  = '0;
        for (int unsigned i = 0; i < NUM_SLV; i++) begin
            req_oh_c[i] = (IW'(i) == req_idx_c);
            if (IW'(i) == idx_q) begin
                sel_oh_c[i] = 1'b1;
                sel_rdy_c   = m_rdy[i];
                sel_rdata_c = m_rdata[i*DW +: DW];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    logic to_clr_c;
    logic to_en_c;
    assign to_clr_c = (state_q == SETUP);
    assign to_en_c  = (state_q == ACCESS);

    apb_timeout_cnt u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (to_clr_c),
        .en       (to_en_c),
        .limit    (TIMEOUT_CYC - TO_CNT_W'(1)),
        .expire_c (timeout_c)
    );
`else
    logic unused_timeout_c;
    assign unused_timeout_c = ^TIMEOUT_CYC;
    assign timeout_c        = 1'b0;
`endif

    // Next state and next registered outputs; outputs are the values for the state being entered.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        m_ce_d      = '0;
        m_enable_d  = 1'b0;
        m_addr_d    = m_addr;
        m_wdata_d   = m_wdata;
        m_we_d      = m_we;
        s_rdy_d     = 1'b0;
        s_rdata_d   = '0;
        err_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_ce && s_enable) begin
                    if (req_mapped_c) begin
                        state_d   = SETUP;
                        idx_d     = req_idx_c;
                        m_ce_d    = req_oh_c;
                        m_addr_d  = s_addr;
                        m_wdata_d = s_wdata;
                        m_we_d    = s_we;
                    end else begin
                        state_d     = RESP;
                        s_rdy_d     = 1'b1;
                        s_rdata_d   = ERR_DATA;
                        err_pulse_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                m_ce_d     = sel_oh_c;
                m_enable_d = 1'b1;
            end
            ACCESS: begin
                if (sel_rdy_c) begin
                    state_d   = RESP;
                    s_rdy_d   = 1'b1;
                    s_rdata_d = m_we ? '0 : sel_rdata_c;
                end else if (timeout_c) begin
                    state_d     = RESP;
                    s_rdy_d     = 1'b1;
                    s_rdata_d   = ERR_DATA;
                    err_pulse_d = 1'b1;
                end else begin
                    m_ce_d     = sel_oh_c;
                    m_enable_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched slave index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Registered outputs and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ce      <= '0;
            m_addr    <= '0;
            m_wdata   <= '0;
            m_enable  <= 1'b0;
            m_we      <= 1'b0;
            s_rdy     <= 1'b0;
            s_rdata   <= '0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            m_ce      <= m_ce_d;
            m_addr    <= m_addr_d;
            m_wdata   <= m_wdata_d;
            m_enable  <= m_enable_d;
            m_we      <= m_we_d;
            s_rdy     <= s_rdy_d;
            s_rdata   <= s_rdata_d;
            err_pulse <= err_pulse_d;
            if (err_pulse_d && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_mux_32bit.sv
// Directed bench for apb_slave_mux_32bit with a transaction-level timing model and per-cycle compare.
module tb_apb_slave_mux_32bit;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_ce = 1'b0;
    logic [23:0]  s_addr = '0;
    logic [31:0]  s_wdata = '0;
    logic         s_enable = 1'b0;
    logic         s_we = 1'b0;
    logic         s_rdy;
    logic [31:0]  s_rdata;
    logic [3:0]   m_ce;
    logic [23:0]  m_addr;
    logic [31:0]  m_wdata;
    logic         m_enable;
    logic         m_we;
    logic [3:0]   m_rdy = 4'hF;
    logic [127:0] m_rdata = '0;
    logic         err_pulse;
    logic [7:0]   err_cnt;

    apb_slave_mux_32bit #(
        .NUM_SLV     (4),
        .AW          (24),
        .DW          (32),
        .SEL_LSB     (20),
        .TIMEOUT_CYC (16'd16),
        .ERR_DATA    (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_ce      (s_ce),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_enable  (s_enable),
        .s_we      (s_we),
        .s_rdy     (s_rdy),
        .s_rdata   (s_rdata),
        .m_ce      (m_ce),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_enable  (m_enable),
        .m_we      (m_we),
        .m_rdy     (m_rdy),
        .m_rdata   (m_rdata),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Transaction model: one outstanding request, described by its start edge and outcome.
    bit          t_act = 1'b0;
    int          t_start;
    bit          t_mapped;
    int          t_idx;
    int          t_weff;
    bit          t_err;
    bit          t_we;
    logic [23:0] t_addr;
    logic [31:0] t_wdata;
    logic [31:0] t_rdata;
    int          exp_err_cnt = 0;

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int          rel;
        logic [3:0]  e_ce;
        bit          e_en, e_rdy, e_ep;
        logic [31:0] e_rd;
        e_ce = '0; e_en = 0; e_rdy = 0; e_ep = 0; e_rd = '0;
        if (t_act && !rst) begin
            rel = edge_n - t_start;
            if (!t_mapped) begin
                if (rel == 0) begin
                    e_rdy = 1; e_ep = 1; e_rd = ERR;
                end
            end else begin
                if (rel >= 0 && rel <= 1 + t_weff) begin
                    e_ce = 4'b0001 << t_idx;
                    e_en = (rel >= 1);
                end
                if (rel == 2 + t_weff) begin
                    e_rdy = 1;
                    e_ep  = t_err;
                    e_rd  = t_err ? ERR : (t_we ? 32'h0 : t_rdata);
                end
            end
            if (e_ep && exp_err_cnt < 255) exp_err_cnt++;
        end
        chk("m_ce", m_ce, e_ce);
        chk("m_enable", m_enable, e_en);
        chk("s_rdy", s_rdy, e_rdy);
        chk("err_pulse", err_pulse, e_ep);
        chk("err_cnt", err_cnt, exp_err_cnt);
        if (e_rdy) chk("s_rdata", s_rdata, e_rd);
        if (e_ce != 4'b0) begin
            chk("m_addr", m_addr, t_addr);
            chk("m_wdata", m_wdata, t_wdata);
            chk("m_we", m_we, t_we);
        end
    end

    // Downstream slaves: selected one answers on its sl_w-th ACCESS cycle; unselected ones always assert ready.
    int          sl_w = 0;
    logic [31:0] sl_data = '0;
    int          acc_k = 0;
    always @(negedge clk) begin
        int k;
        if (m_enable && (m_ce != 4'b0)) begin
            k = acc_k;
            acc_k = acc_k + 1;
        end else begin
            k = -1;
            acc_k = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (m_ce[i] && k == sl_w) begin
                m_rdy[i] = 1'b1;
                m_rdata[i*32 +: 32] = sl_data;
            end else if (m_ce[i]) begin
                m_rdy[i] = 1'b0;
                m_rdata[i*32 +: 32] = 32'h0BAD_0000 | 32'(k);
            end else begin
                m_rdy[i] = 1'b1;
                m_rdata[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
            end
        end
    end

    task automatic xfer(input logic [23:0] addr, input bit we, input logic [31:0] wdata,
                        input int w, input logic [31:0] rdata,
                        output int lat, output logic [31:0] got, output logic [3:0] seen_ce,
                        output bit seen_we, output bit ep);
        int upper;
        @(negedge clk);
        upper    = int'(addr >> 20);
        t_start  = edge_n + 1;
        t_mapped = (upper < 4);
        t_idx    = upper & 3;
        t_we     = we;
        t_addr   = addr;
        t_wdata  = wdata;
        t_rdata  = rdata;
        t_weff   = w;
        t_err    = !t_mapped;
`ifdef APB_TIMEOUT_EN
        if (t_mapped && w > TO - 1) begin
            t_weff = TO - 1;
            t_err  = 1;
        end
`endif
        t_act   = 1;
        sl_w    = w;
        sl_data = rdata;
        s_ce = 1; s_enable = 1; s_addr = addr; s_we = we; s_wdata = wdata;
        lat = -1; got = '0; seen_ce = '0; seen_we = 0; ep = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            seen_ce |= m_ce;
            if (m_enable) seen_we = m_we;
            if (s_rdy) begin
                lat = edge_n - t_start;
                got = s_rdata;
                ep  = err_pulse;
                break;
            end
        end
        s_ce = 0; s_enable = 0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_wait: no s_rdy within 100 cycles for addr %h", addr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] got;
        logic [3:0]  ce;
        bit          we, ep;

        #1 rst = 1;
        #2;
        chk("rst_m_ce", m_ce, 4'b0);
        chk("rst_s_rdy", s_rdy, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'h0);
        chk("rst_m_addr", m_addr, 24'h0);
        repeat (2) @(negedge clk);
        rst = 0;

        // Read from slave 2, ready on the second ACCESS cycle.
        xfer(24'h20_0010, 1'b0, 32'h0, 1, 32'h1234_5678, lat, got, ce, we, ep);
        chk("rd2_latency", lat, 3);
        chk("rd2_rdata", got, 32'h1234_5678);
        chk("rd2_m_ce", ce, 4'b0100);
        chk("rd2_err_pulse", ep, 1'b0);

        // Write to slave 0, ready on the third ACCESS cycle.
        xfer(24'h00_0004, 1'b1, 32'hA5A5_0001, 2, 32'h7777_7777, lat, got, ce, we, ep);
        chk("wr0_latency", lat, 4);
        chk("wr0_rdata", got, 32'h0);
        chk("wr0_m_we", we, 1'b1);
        chk("wr0_m_ce", ce, 4'b0001);
        chk("wr0_err_cnt", err_cnt, 8'd0);

        // Unmapped: index 4.
        xfer(24'h40_0000, 1'b0, 32'h0, 0, 32'h0, lat, got, ce, we, ep);
        chk("unm_latency", lat, 0);
        chk("unm_rdata", got, ERR);
        chk("unm_err_pulse", ep, 1'b1);
        chk("unm_m_ce", ce, 4'b0);
        chk("unm_err_cnt", err_cnt, 8'd1);

`ifdef APB_TIMEOUT_EN
        // Slave 1 never ready: forced error after 16 ACCESS cycles.
        xfer(24'h10_0020, 1'b0, 32'h0, 1000, 32'h5555_AAAA, lat, got, ce, we, ep);
        chk("to_latency", lat, 17);
        chk("to_rdata", got, ERR);
        chk("to_err_pulse", ep, 1'b1);
        chk("to_err_cnt", err_cnt, 8'd2);
        // Ready on the expiry cycle wins.
        xfer(24'h10_0024, 1'b0, 32'h0, 15, 32'h0F0F_1111, lat, got, ce, we, ep);
        chk("tie_latency", lat, 17);
        chk("tie_rdata", got, 32'h0F0F_1111);
        chk("tie_err_pulse", ep, 1'b0);
        chk("tie_err_cnt", err_cnt, 8'd2);
`else
        // Without the watchdog a slow slave is simply waited for.
        xfer(24'h10_0020, 1'b0, 32'h0, 20, 32'h5555_AAAA, lat, got, ce, we, ep);
        chk("slow_latency", lat, 22);
        chk("slow_rdata", got, 32'h5555_AAAA);
        chk("slow_err_pulse", ep, 1'b0);
        chk("slow_err_cnt", err_cnt, 8'd1);
`endif

        // Reset in the middle of ACCESS of a read to slave 3.
        @(negedge clk);
        t_start = edge_n + 1; t_mapped = 1; t_idx = 3; t_we = 0;
        t_addr = 24'h30_0008; t_wdata = 32'h1111_2222; t_rdata = 32'h0;
        t_weff = 1000; t_err = 0; t_act = 1;
        sl_w = 1000;
        s_ce = 1; s_enable = 1; s_addr = 24'h30_0008; s_we = 0; s_wdata = 32'h1111_2222;
        repeat (4) @(negedge clk);
        chk("pre_rst_m_enable", m_enable, 1'b1);
        #2;
        rst = 1; t_act = 0; exp_err_cnt = 0;
        #1;
        chk("arst_m_ce", m_ce, 4'b0);
        chk("arst_m_enable", m_enable, 1'b0);
        chk("arst_m_addr", m_addr, 24'h0);
        chk("arst_m_wdata", m_wdata, 32'h0);
        chk("arst_m_we", m_we, 1'b0);
        chk("arst_s_rdy", s_rdy, 1'b0);
        chk("arst_s_rdata", s_rdata, 32'h0);
        chk("arst_err_pulse", err_pulse, 1'b0);
        chk("arst_err_cnt", err_cnt, 8'h0);
        s_ce = 0; s_enable = 0;
        repeat (2) @(negedge clk);
        rst = 0;

        // Normal request after reset release.
        xfer(24'h30_0008, 1'b0, 32'h0, 0, 32'hCAFE_F00D, lat, got, ce, we, ep);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_rdata", got, 32'hCAFE_F00D);
        chk("post_rst_m_ce", ce, 4'b1000);

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            xfer(24'((4 + (i % 12)) << 20) | 24'(i), 1'(i & 1), 32'(i), 0, 32'h0,
                 lat, got, ce, we, ep);
        end
        chk("sat_err_cnt", err_cnt, 8'hFF);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
